// File: rtl/dec_stage_pkg.sv
// Shared decode definitions: opcode constants, class bit indices, packet layout.
package dec_stage_pkg;

  // pc and imm are carried at full 64-bit width; a 32-bit stage leaves bits 63:32 zero.
  localparam int unsigned XLEN_MAX = 64;
  localparam int unsigned CLS_NUM  = 13;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum int unsigned {
    CLS_LOAD      = 0,
    CLS_STORE     = 1,
    CLS_BRANCH    = 2,
    CLS_JALR      = 3,
    CLS_JAL       = 4,
    CLS_LUI       = 5,
    CLS_AUIPC     = 6,
    CLS_OP_IMM    = 7,
    CLS_OP        = 8,
    CLS_SYSTEM    = 9,
    CLS_MISC_MEM  = 10,
    CLS_OP_IMM_32 = 11,
    CLS_OP_32     = 12
  } dec_cls_e;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         instr;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [XLEN_MAX-1:0] imm;
    logic [CLS_NUM-1:0]  cls;
    logic                illegal;
    logic                rs1_used;
    logic                rs2_used;
    logic                rd_we;
  } dec_pkt_t;

  function automatic logic [CLS_NUM-1:0] cls_onehot(input dec_cls_e c);
    logic [CLS_NUM-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_comb.sv
// Combinational RV32I/RV64I field decode of one instruction word.
module dec_comb
  import dec_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          FENCE_EN = 1'b1
) (
  input  logic [63:0] i_pc,
  input  logic [31:0] i_instr,
  output dec_pkt_t    o_pkt
);

  localparam logic [63:0] IMM_MASK = (XLEN == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;

  logic [CLS_NUM-1:0] w_cls;
  imm_fmt_e           w_fmt;
  logic               w_illegal;
  logic [63:0]        w_imm64;
  logic               w_writes;

  // Opcode class and immediate format; disabled classes simply never match.
  always_comb begin
    w_cls = '0;
    w_fmt = FMT_NONE;
    if (i_instr[1:0] == 2'b11) begin
      case (i_instr[6:0])
        OPC_LOAD:   begin w_cls = cls_onehot(CLS_LOAD);   w_fmt = FMT_I; end
        OPC_STORE:  begin w_cls = cls_onehot(CLS_STORE);  w_fmt = FMT_S; end
        OPC_BRANCH: begin w_cls = cls_onehot(CLS_BRANCH); w_fmt = FMT_B; end
        OPC_JALR:   begin w_cls = cls_onehot(CLS_JALR);   w_fmt = FMT_I; end
        OPC_JAL:    begin w_cls = cls_onehot(CLS_JAL);    w_fmt = FMT_J; end
        OPC_LUI:    begin w_cls = cls_onehot(CLS_LUI);    w_fmt = FMT_U; end
        OPC_AUIPC:  begin w_cls = cls_onehot(CLS_AUIPC);  w_fmt = FMT_U; end
        OPC_OP_IMM: begin w_cls = cls_onehot(CLS_OP_IMM); w_fmt = FMT_I; end
        OPC_OP:     begin w_cls = cls_onehot(CLS_OP); end
        OPC_SYSTEM: begin w_cls = cls_onehot(CLS_SYSTEM); w_fmt = FMT_I; end
        OPC_MISC_MEM: begin
          if (FENCE_EN) w_cls = cls_onehot(CLS_MISC_MEM);
        end
        // OP_IMM_32 shares the I format of the OP_IMM family.
        OPC_OP_IMM_32: begin
          if (XLEN == 64) begin
            w_cls = cls_onehot(CLS_OP_IMM_32);
            w_fmt = FMT_I;
          end
        end
        OPC_OP_32: begin
          if (XLEN == 64) w_cls = cls_onehot(CLS_OP_32);
        end
        default: ;
      endcase
    end
  end

  // Format-selected immediate, sign-extended from instr[31] to 64 bits.
  always_comb begin
    w_imm64 = '0;
    case (w_fmt)
      FMT_I: w_imm64 = {{52{i_instr[31]}}, i_instr[31:20]};
      FMT_S: w_imm64 = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B: w_imm64 = {{51{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                        i_instr[11:8], 1'b0};
      FMT_U: w_imm64 = {{32{i_instr[31]}}, i_instr[31:12], 12'h000};
      FMT_J: w_imm64 = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      default: w_imm64 = '0;
    endcase
  end

  // Packet assembly; an illegal word keeps its raw fields but no class or side effects.
  always_comb begin
    w_illegal = (w_cls == '0) || (i_instr == '0);
    w_writes  = w_cls[CLS_LOAD] | w_cls[CLS_JALR] | w_cls[CLS_JAL] | w_cls[CLS_LUI] |
                w_cls[CLS_AUIPC] | w_cls[CLS_OP_IMM] | w_cls[CLS_OP] | w_cls[CLS_SYSTEM] |
                w_cls[CLS_OP_IMM_32] | w_cls[CLS_OP_32];
    o_pkt          = '0;
    o_pkt.pc       = i_pc;
    o_pkt.instr    = i_instr;
    o_pkt.rd       = i_instr[11:7];
    o_pkt.rs1      = i_instr[19:15];
    o_pkt.rs2      = i_instr[24:20];
    o_pkt.funct3   = i_instr[14:12];
    o_pkt.funct7   = i_instr[31:25];
    o_pkt.imm      = w_illegal ? '0 : (w_imm64 & IMM_MASK);
    o_pkt.cls      = w_illegal ? '0 : w_cls;
    o_pkt.illegal  = w_illegal;
    o_pkt.rs1_used = !w_illegal && !(w_cls[CLS_LUI] | w_cls[CLS_AUIPC] | w_cls[CLS_JAL]);
    o_pkt.rs2_used = !w_illegal && (w_cls[CLS_STORE] | w_cls[CLS_BRANCH] | w_cls[CLS_OP] |
                                    w_cls[CLS_OP_32]);
    o_pkt.rd_we    = !w_illegal && w_writes && (i_instr[11:7] != 5'd0);
  end

endmodule

// File: rtl/dec_stage.sv
// Registered decode stage: 2-entry skid buffer, flush and issue counter.
module dec_stage
  import dec_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          FENCE_EN = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output dec_pkt_t         out_pkt,
  output logic [CNT_W-1:0] dec_count
);

  logic [1:0]       r_occ;
  logic             r_in_ready;
  dec_pkt_t         r_ent0;
  dec_pkt_t         r_ent1;
  logic [CNT_W-1:0] r_count;

  logic [63:0]      w_pc64;
  dec_pkt_t         w_dec;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_pc64     = 64'(in_pc);
  assign in_ready   = r_in_ready;
  assign out_valid  = (r_occ != 2'd0);
  assign out_pkt    = r_ent0;
  assign dec_count  = r_count;
  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = out_valid && out_ready;

  dec_comb #(
    .XLEN     (XLEN),
    .FENCE_EN (FENCE_EN)
  ) u_dec_comb (
    .i_pc    (w_pc64),
    .i_instr (in_instr),
    .o_pkt   (w_dec)
  );

  // Skid buffer: entry0 is the head, entry1 absorbs a beat while the head stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_in_ready <= 1'b1;
      r_ent0     <= '0;
      r_ent1     <= '0;
    end else if (flush) begin
      r_occ      <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      case ({w_in_fire, w_out_fire})
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_ent0 <= r_ent1;
            r_ent1 <= w_dec;
          end else begin
            r_ent0 <= w_dec;
          end
        end
        2'b10: begin
          if (r_occ == 2'd0) r_ent0 <= w_dec;
          else               r_ent1 <= w_dec;
          r_occ      <= r_occ + 2'd1;
          r_in_ready <= (r_occ == 2'd0);
        end
        2'b01: begin
          r_ent0     <= r_ent1;
          r_occ      <= r_occ - 2'd1;
          r_in_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Issued-packet counter; flush does not disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_out_fire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dec_stage.sv
// Self-checking bench for dec_stage: a 32-bit and a 64-bit instance share stimulus.
module tb_dec_stage;
  import dec_stage_pkg::*;

  typedef struct {
    bit [63:0] pc;
    bit [31:0] ins;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  dec_pkt_t    pkt32, pkt64;
  logic [31:0] cnt32;
  logic [3:0]  cnt64;

  int checks = 0;
  int errors = 0;

  beat_t     q[$];
  bit [31:0] mcount = 0;
  bit        started = 0;
  bit        just_reset = 0;

  dec_stage #(.XLEN(32), .FENCE_EN(1'b1), .CNT_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_pc(in_pc[31:0]), .in_instr(in_instr), .out_valid(out_valid32),
    .out_ready(out_ready), .out_pkt(pkt32), .dec_count(cnt32)
  );

  dec_stage #(.XLEN(64), .FENCE_EN(1'b0), .CNT_W(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid64),
    .out_ready(out_ready), .out_pkt(pkt64), .dec_count(cnt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode from the ISA tables: immediates built arithmetically.
  function automatic dec_pkt_t model(input bit [63:0] pc, input bit [31:0] ins,
                                     input int xlen, input bit fence);
    dec_pkt_t p;
    int       c;
    byte      f;
    longint   v;
    p = '0;
    c = -1;
    f = "N";
    v = 0;
    case (ins[6:0])
      7'h03: begin c = CLS_LOAD;   f = "I"; end
      7'h23: begin c = CLS_STORE;  f = "S"; end
      7'h63: begin c = CLS_BRANCH; f = "B"; end
      7'h67: begin c = CLS_JALR;   f = "I"; end
      7'h6F: begin c = CLS_JAL;    f = "J"; end
      7'h37: begin c = CLS_LUI;    f = "U"; end
      7'h17: begin c = CLS_AUIPC;  f = "U"; end
      7'h13: begin c = CLS_OP_IMM; f = "I"; end
      7'h33: c = CLS_OP;
      7'h73: begin c = CLS_SYSTEM; f = "I"; end
      7'h0F: if (fence) c = CLS_MISC_MEM;
      7'h1B: if (xlen == 64) begin c = CLS_OP_IMM_32; f = "I"; end
      7'h3B: if (xlen == 64) c = CLS_OP_32;
      default: ;
    endcase
    p.illegal = (ins[1:0] != 2'b11) || (c < 0) || (ins == 32'h0);
    if (p.illegal) c = -1;
    if (c >= 0) begin
      case (f)
        "I": v = $signed(ins[31:20]);
        "S": v = $signed({ins[31:25], ins[11:7]});
        "B": v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
        "U": v = $signed(ins[31:12]) * 4096;
        "J": v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
        default: v = 0;
      endcase
      p.cls[c] = 1'b1;
    end
    if (xlen == 32) begin
      v  = v & 64'hFFFF_FFFF;
      pc = pc & 64'hFFFF_FFFF;
    end
    p.pc       = pc;
    p.instr    = ins;
    p.rd       = ins[11:7];
    p.rs1      = ins[19:15];
    p.rs2      = ins[24:20];
    p.funct3   = ins[14:12];
    p.funct7   = ins[31:25];
    p.imm      = v;
    p.rs1_used = (c >= 0) && !(c inside {CLS_LUI, CLS_AUIPC, CLS_JAL});
    p.rs2_used = (c >= 0) && (c inside {CLS_STORE, CLS_BRANCH, CLS_OP, CLS_OP_32});
    p.rd_we    = (c >= 0) && !(c inside {CLS_STORE, CLS_BRANCH, CLS_MISC_MEM}) &&
                 (ins[11:7] != 5'd0);
    return p;
  endfunction

  // Stage behaviour as a bounded FIFO of beats.
  always @(posedge clk) begin
    bit ofire, ifire;
    if (rst) begin
      q.delete();
      mcount     = 0;
      started    = 1;
      just_reset = 1;
    end else begin
      just_reset = 0;
      ofire = (q.size() > 0) && out_ready;
      ifire = in_valid && (q.size() < 2);
      if (ofire) mcount++;
      if (flush) begin
        q.delete();
      end else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back('{pc: in_pc, ins: in_instr});
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    dec_pkt_t e32, e64;
    if (started) begin
      chk("in_ready32", 256'(in_ready32), 256'(q.size() < 2));
      chk("in_ready64", 256'(in_ready64), 256'(q.size() < 2));
      chk("out_valid32", 256'(out_valid32), 256'(q.size() > 0));
      chk("out_valid64", 256'(out_valid64), 256'(q.size() > 0));
      chk("count32", 256'(cnt32), 256'(mcount));
      chk("count64", 256'(cnt64), 256'(mcount[3:0]));
      if (just_reset) begin
        chk("rst_pkt32", 256'(pkt32), 256'(0));
        chk("rst_pkt64", 256'(pkt64), 256'(0));
      end else if (q.size() > 0) begin
        e32 = model(q[0].pc, q[0].ins, 32, 1'b1);
        e64 = model(q[0].pc, q[0].ins, 64, 1'b0);
        chk("pkt32", 256'(pkt32), 256'(e32));
        chk("pkt64", 256'(pkt64), 256'(e64));
      end
    end
  end

  task automatic cyc(input bit v, input bit [31:0] ins, input bit [63:0] pc,
                     input bit ordy, input bit fl, input bit r);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  function automatic bit [31:0] rand_instr();
    bit [6:0]  opcs[13] = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17,
                            7'h13, 7'h33, 7'h73, 7'h0F, 7'h1B, 7'h3B};
    bit [31:0] r;
    int        k;
    r = $urandom();
    k = $urandom_range(0, 16);
    if (k < 13)       r[6:0] = opcs[k];
    else if (k == 13) r[6:0] = 7'h7F;
    else if (k == 15) r = 32'h0;
    else if (k == 16) r[1:0] = 2'b00;
    return r;
  endfunction

  initial begin
    dec_pkt_t  t;
    bit [63:0] rpc;

    // Pin the model against hand-decoded words.
    t = model(64'h0, 32'hFFF00093, 32, 1'b1);
    chk("m_addi_imm", 256'(t.imm), 256'(64'h0000_0000_FFFF_FFFF));
    t = model(64'h0, 32'hFE000EE3, 32, 1'b1);
    chk("m_beq_imm", 256'(t.imm), 256'(64'h0000_0000_FFFF_FFFC));
    t = model(64'h0, 32'h800000EF, 64, 1'b1);
    chk("m_jal_imm", 256'(t.imm), 256'(64'hFFFF_FFFF_FFF0_0000));
    t = model(64'h0, 32'h80000037, 64, 1'b1);
    chk("m_lui_imm", 256'(t.imm), 256'(64'hFFFF_FFFF_8000_0000));
    t = model(64'h0, 32'h00000010, 32, 1'b1);
    chk("m_ill", 256'({t.illegal, t.cls, t.rd_we}), 256'({1'b1, 13'h0, 1'b0}));

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // ADDI x1,x0,-1 straight through.
    cyc(1, 32'hFFF00093, 64'h100, 1, 0, 0);
    chk("t1_valid", 256'(out_valid32), 256'(1));
    chk("t1_imm32", 256'(pkt32.imm), 256'(64'h0000_0000_FFFF_FFFF));
    chk("t1_imm64", 256'(pkt64.imm), 256'(64'hFFFF_FFFF_FFFF_FFFF));
    chk("t1_cls", 256'(pkt32.cls), 256'(13'h080));
    chk("t1_regs", 256'({pkt32.rd, pkt32.rd_we, pkt32.rs2_used}), 256'({5'd1, 1'b1, 1'b0}));
    cyc(0, 0, 0, 1, 0, 0);
    chk("t1_count", 256'(cnt32), 256'(1));

    // Fill the skid buffer, then release.
    cyc(1, 32'h00208133, 64'h104, 1, 0, 0);
    cyc(1, 32'hFE000EE3, 64'h108, 0, 0, 0);
    chk("t2_full_ready", 256'(in_ready32), 256'(0));
    cyc(1, 32'h800000EF, 64'h10C, 0, 0, 0);
    cyc(1, 32'h800000EF, 64'h10C, 1, 0, 0);
    chk("t2_beq_imm", 256'(pkt32.imm), 256'(64'h0000_0000_FFFF_FFFC));
    cyc(1, 32'h800000EF, 64'h10C, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Continuous input with out_ready toggling 1010.
    for (int i = 0; i < 40; i++)
      cyc(1, rand_instr(), 64'h200 + 64'(4 * i), (i % 2) == 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);

    // Illegal words.
    cyc(1, 32'h00000000, 64'h300, 1, 0, 0);
    cyc(1, 32'h00000010, 64'h304, 1, 0, 0);
    chk("t4_ill", 256'({pkt32.illegal, pkt32.cls, pkt32.rd_we}), 256'({1'b1, 13'h0, 1'b0}));
    cyc(1, 32'hFFFFFFFF, 64'h308, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Flush at occupancy 2 with a beat arriving.
    cyc(1, 32'h00108093, 64'h400, 0, 0, 0);
    cyc(1, 32'h00210113, 64'h404, 0, 0, 0);
    cyc(1, 32'h00318193, 64'h408, 1, 1, 0);
    chk("t5_flush_valid", 256'(out_valid32), 256'(0));
    cyc(0, 0, 0, 1, 0, 0);

    // Reset at occupancy 1, then LUI sign-extension.
    cyc(1, 32'h00208133, 64'h500, 0, 0, 0);
    cyc(1, 32'h00308133, 64'h504, 1, 0, 1);
    chk("t6_rst", 256'({out_valid32, in_ready32, cnt32, pkt32}), 256'({1'b0, 1'b1, 32'h0}) << $bits(dec_pkt_t));
    cyc(1, 32'h80000037, 64'h600, 1, 0, 0);
    chk("t6_lui64", 256'(pkt64.imm), 256'(64'hFFFF_FFFF_8000_0000));
    chk("t6_lui32", 256'(pkt32.imm), 256'(64'h0000_0000_8000_0000));
    cyc(0, 0, 0, 1, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rpc = {$urandom(), $urandom()};
      cyc(($urandom() % 4) != 0, rand_instr(), rpc, ($urandom() % 3) != 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
